srl_fifo: RTL



---
 rtl/srl_fifo.sv | 126 ++++++++++++
 1 files changed

// File: rtl/srl_fifo.sv
// 33-word ready/valid FIFO: 32-deep per-bit shift-register storage plus an output register.
// Define SRL_FIFO_LEVEL_EN to generate LEVEL/ALMOST_FULL/ALMOST_EMPTY; otherwise they tie to 0.
module srl_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned AFULL_THR  = 28,
  parameter int unsigned AEMPTY_THR = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [WIDTH-1:0] S_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [WIDTH-1:0] M_DATA,
  output logic [5:0]       LEVEL,
  output logic             ALMOST_FULL,
  output logic             ALMOST_EMPTY
);

  localparam logic [5:0] SRL_DEPTH = 6'd32;

  logic [WIDTH-1:0] srl_mem [32];
  logic [5:0]       cnt_q, cnt_d;
  logic             ovld_q, ovld_d;
  logic             s_ready_q, s_ready_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             push, pop, load;
  logic [5:0]       cnt_m1;
  logic [4:0]       srl_addr;
  logic [WIDTH-1:0] srl_out;

  // Storage carries no reset so it maps onto SRL32E shift registers (CE = push).
  always_ff @(posedge CLK) begin
    if (push) begin
      srl_mem[0] <= S_DATA;
      for (int unsigned i = 1; i < 32; i++) begin
        srl_mem[i] <= srl_mem[i-1];
      end
    end
  end

  always_comb begin
    cnt_m1   = cnt_q - 6'd1;
    srl_addr = (cnt_q != '0) ? cnt_m1[4:0] : '0;
    srl_out  = srl_mem[srl_addr];
  end

  always_comb begin
    push = S_VALID & s_ready_q;
    pop  = ovld_q & M_READY;
    load = (cnt_q != '0) & (~ovld_q | pop);

    cnt_d = cnt_q;
    unique case ({push, load})
      2'b10:   cnt_d = cnt_q + 6'd1;
      2'b01:   cnt_d = cnt_q - 6'd1;
      default: cnt_d = cnt_q;
    endcase

    ovld_d   = ovld_q;
    m_data_d = m_data_q;
    if (load) begin
      ovld_d   = 1'b1;
      m_data_d = srl_out;
    end else if (pop) begin
      ovld_d   = 1'b0;
    end

    s_ready_d = (cnt_d != SRL_DEPTH);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q     <= '0;
      ovld_q    <= 1'b0;
      s_ready_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      ovld_q    <= ovld_d;
      s_ready_q <= s_ready_d;
      m_data_q  <= m_data_d;
    end
  end

  assign S_READY = s_ready_q;
  assign M_VALID = ovld_q;
  assign M_DATA  = m_data_q;

`ifdef SRL_FIFO_LEVEL_EN
  localparam logic [5:0] AFULL_L  = 6'(AFULL_THR);
  localparam logic [5:0] AEMPTY_L = 6'(AEMPTY_THR);

  logic [5:0] level_q, level_d;
  logic       afull_q, afull_d;
  logic       aempty_q, aempty_d;

  always_comb begin
    level_d  = cnt_d + {5'd0, ovld_d};
    afull_d  = (level_d >= AFULL_L);
    aempty_d = (level_d <= AEMPTY_L);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      level_q  <= '0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      level_q  <= level_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  assign LEVEL        = level_q;
  assign ALMOST_FULL  = afull_q;
  assign ALMOST_EMPTY = aempty_q;
`else
  assign LEVEL        = '0;
  assign ALMOST_FULL  = 1'b0;
  assign ALMOST_EMPTY = 1'b0;
`endif

endmodule
